// File: rtl/quiz_round_ctrl_if.sv
// Player/display side of the quiz round sequencer: control strobes in, phase and score state out.
interface quiz_round_ctrl_if;
    logic       start;
    logic       abort;
    logic       answer_valid;
    logic       answer_correct;
    logic [1:0] phase;
    logic       new_question;
    logic [7:0] time_left;
    logic [3:0] round_idx;
    logic [3:0] score;
    logic       last_correct;
    logic       timeout;
    logic       done;

    modport master (
        output start, abort, answer_valid, answer_correct,
        input  phase, new_question, time_left, round_idx, score, last_correct, timeout, done
    );

    modport slave (
        input  start, abort, answer_valid, answer_correct,
        output phase, new_question, time_left, round_idx, score, last_correct, timeout, done
    );
endinterface

// File: rtl/quiz_round_ctrl.sv
// Quiz round sequencer: SHOW -> ANSWER -> FEEDBACK per question, timed by a prescaled tick,
// scoring NUM_ROUNDS questions per game.
module quiz_round_ctrl #(
    parameter int TICK_DIV       = 500,
    parameter int SHOW_TICKS     = 2,
    parameter int ANSWER_TICKS   = 10,
    parameter int FEEDBACK_TICKS = 3,
    parameter int NUM_ROUNDS     = 8
) (
    input  logic          clk_in,
    input  logic          reset,
    quiz_round_ctrl_if.slave bus
);
    localparam int CW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        SHOW     = 2'b01,
        ANSWER   = 2'b10,
        FEEDBACK = 2'b11
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] presc;
    logic [7:0]    time_left;
    logic [3:0]    round_idx, score;
    logic          last_correct, timeout, new_question, done;
    logic          tick, phase_end, last_round;
    logic          game_start, ans_hit, ans_to, fb_next, fb_done;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        tick       = (presc == CW'(TICK_DIV - 1));
        phase_end  = tick && (time_left == 8'd1);
        last_round = (round_idx == 4'(NUM_ROUNDS - 1));
        state_nxt  = state;
        game_start = 1'b0;
        ans_hit    = 1'b0;
        ans_to     = 1'b0;
        fb_next    = 1'b0;
        fb_done    = 1'b0;
        // abort outranks everything, including a start seen in IDLE
        if (bus.abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    state_nxt  = SHOW;
                    game_start = 1'b1;
                end
                SHOW: if (phase_end) state_nxt = ANSWER;
                ANSWER: begin
                    // an answer arriving with the final tick still counts as an answer
                    if (bus.answer_valid) begin
                        state_nxt = FEEDBACK;
                        ans_hit   = 1'b1;
                    end else if (phase_end) begin
                        state_nxt = FEEDBACK;
                        ans_to    = 1'b1;
                    end
                end
                FEEDBACK: if (phase_end) begin
                    if (last_round) begin
                        state_nxt = IDLE;
                        fb_done   = 1'b1;
                    end else begin
                        state_nxt = SHOW;
                        fb_next   = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            presc        <= '0;
            time_left    <= '0;
            round_idx    <= '0;
            score        <= '0;
            last_correct <= 1'b0;
            timeout      <= 1'b0;
            new_question <= 1'b0;
            done         <= 1'b0;
        end else begin
            new_question <= (state_nxt == SHOW) && (state != SHOW);
            done         <= fb_done;

            // every state change restarts the prescaler so phases are whole ticks long
            if (state_nxt != state || state_nxt == IDLE || tick) presc <= '0;
            else                                                  presc <= presc + 1'b1;

            if (state_nxt != state) begin
                case (state_nxt)
                    SHOW:     time_left <= 8'(SHOW_TICKS);
                    ANSWER:   time_left <= 8'(ANSWER_TICKS);
                    FEEDBACK: time_left <= 8'(FEEDBACK_TICKS);
                    default:  time_left <= '0;
                endcase
            end else if (tick && state != IDLE) begin
                time_left <= time_left - 8'd1;
            end

            if (game_start) begin
                round_idx    <= '0;
                score        <= '0;
                last_correct <= 1'b0;
                timeout      <= 1'b0;
            end
            if (ans_hit) begin
                last_correct <= bus.answer_correct;
                timeout      <= 1'b0;
                score        <= score + {3'b000, bus.answer_correct};
            end
            if (ans_to) begin
                last_correct <= 1'b0;
                timeout      <= 1'b1;
            end
            if (fb_next) round_idx <= round_idx + 4'd1;
        end
    end

    assign bus.phase        = state;
    assign bus.new_question = new_question;
    assign bus.time_left    = time_left;
    assign bus.round_idx    = round_idx;
    assign bus.score        = score;
    assign bus.last_correct = last_correct;
    assign bus.timeout      = timeout;
    assign bus.done         = done;
endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Directed bench for quiz_round_ctrl with a small configuration (4-cycle tick, 2 rounds).
module tb_quiz_round_ctrl;
    logic clk_in = 1'b0;
    logic reset  = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n;

    quiz_round_ctrl_if bus();

    quiz_round_ctrl #(
        .TICK_DIV(4), .SHOW_TICKS(2), .ANSWER_TICKS(3), .FEEDBACK_TICKS(1), .NUM_ROUNDS(2)
    ) dut (
        .clk_in(clk_in),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    // cycles spent in phase ph from the current sample on; bounded
    task automatic measure(input logic [1:0] ph, output int cnt);
        cnt = 0;
        while (bus.phase == ph && cnt < 200) begin
            cnt++;
            cyc();
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic answer(input logic correct);
        bus.answer_valid   = 1'b1;
        bus.answer_correct = correct;
        cyc();
        bus.answer_valid   = 1'b0;
        bus.answer_correct = 1'b0;
    endtask

    initial begin
        int pulses;
        bus.start = 0; bus.abort = 0; bus.answer_valid = 0; bus.answer_correct = 0;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        chk("rst_phase", 32'(bus.phase), 0);
        chk("rst_time_left", 32'(bus.time_left), 0);
        chk("rst_score", 32'(bus.score), 0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.new_question || bus.done) pulses++;
            cyc();
        end
        chk("idle_pulses", 32'(pulses), 0);

        // game with no answers: both rounds time out
        pulse_start();
        chk("g1_phase_show", 32'(bus.phase), 1);
        chk("g1_nq", 32'(bus.new_question), 1);
        chk("g1_time_left", 32'(bus.time_left), 2);
        chk("g1_round0", 32'(bus.round_idx), 0);
        measure(2'b01, n); chk("g1_show_len", 32'(n), 8);
        measure(2'b10, n); chk("g1_answer_len", 32'(n), 12);
        chk("g1_fb_phase", 32'(bus.phase), 3);
        chk("g1_timeout", 32'(bus.timeout), 1);
        chk("g1_last_correct", 32'(bus.last_correct), 0);
        measure(2'b11, n); chk("g1_fb_len", 32'(n), 4);
        chk("g1_r1_nq", 32'(bus.new_question), 1);
        chk("g1_round1", 32'(bus.round_idx), 1);
        cyc();
        chk("g1_nq_width", 32'(bus.new_question), 0);
        measure(2'b01, n); chk("g1_r1_show_len", 32'(n), 7);
        measure(2'b10, n); chk("g1_r1_answer_len", 32'(n), 12);
        measure(2'b11, n); chk("g1_r1_fb_len", 32'(n), 4);
        chk("g1_done", 32'(bus.done), 1);
        chk("g1_end_phase", 32'(bus.phase), 0);
        chk("g1_end_score", 32'(bus.score), 0);
        chk("g1_end_round", 32'(bus.round_idx), 1);
        cyc();
        chk("g1_done_width", 32'(bus.done), 0);

        // game with correct answers 2 cycles into ANSWER
        pulse_start();
        measure(2'b01, n); chk("g2_show_len", 32'(n), 8);
        cyc();
        answer(1'b1);
        chk("g2_r0_phase", 32'(bus.phase), 3);
        chk("g2_r0_score", 32'(bus.score), 1);
        chk("g2_r0_lc", 32'(bus.last_correct), 1);
        chk("g2_r0_to", 32'(bus.timeout), 0);
        chk("g2_r0_tl", 32'(bus.time_left), 1);
        measure(2'b11, n); chk("g2_fb_len", 32'(n), 4);
        chk("g2_round1", 32'(bus.round_idx), 1);
        measure(2'b01, n);
        cyc();
        answer(1'b1);
        chk("g2_r1_phase", 32'(bus.phase), 3);
        chk("g2_r1_score", 32'(bus.score), 2);
        measure(2'b11, n);
        chk("g2_done", 32'(bus.done), 1);
        chk("g2_end_phase", 32'(bus.phase), 0);
        chk("g2_end_score", 32'(bus.score), 2);
        chk("g2_end_lc", 32'(bus.last_correct), 1);
        cyc();

        // answer on the final tick; answers in SHOW/FEEDBACK ignored
        pulse_start();
        chk("g3_start_score", 32'(bus.score), 0);
        answer(1'b1);
        chk("g3_show_ignore_phase", 32'(bus.phase), 1);
        chk("g3_show_ignore_score", 32'(bus.score), 0);
        measure(2'b01, n);
        repeat (11) cyc();
        chk("g3_last_tick_phase", 32'(bus.phase), 2);
        chk("g3_last_tick_tl", 32'(bus.time_left), 1);
        answer(1'b1);
        chk("g3_final_phase", 32'(bus.phase), 3);
        chk("g3_final_score", 32'(bus.score), 1);
        chk("g3_final_to", 32'(bus.timeout), 0);
        chk("g3_final_lc", 32'(bus.last_correct), 1);
        answer(1'b1);
        chk("g3_fb_ignore_phase", 32'(bus.phase), 3);
        chk("g3_fb_ignore_score", 32'(bus.score), 1);
        measure(2'b11, n);
        chk("g3_round1", 32'(bus.round_idx), 1);

        // abort mid-ANSWER of round 1
        measure(2'b01, n);
        repeat (2) cyc();
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        chk("ab_phase", 32'(bus.phase), 0);
        chk("ab_done", 32'(bus.done), 0);
        chk("ab_score", 32'(bus.score), 1);
        chk("ab_round", 32'(bus.round_idx), 1);
        chk("ab_tl", 32'(bus.time_left), 0);
        cyc();
        chk("ab_done_later", 32'(bus.done), 0);
        bus.abort = 1'b1;
        bus.start = 1'b1;
        cyc();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        chk("ab_start_phase", 32'(bus.phase), 0);
        chk("ab_start_nq", 32'(bus.new_question), 0);
        pulse_start();
        chk("ab_restart_phase", 32'(bus.phase), 1);
        chk("ab_restart_score", 32'(bus.score), 0);
        chk("ab_restart_round", 32'(bus.round_idx), 0);

        // async reset mid-SHOW of round 1 with score 1
        measure(2'b01, n);
        answer(1'b1);
        measure(2'b11, n);
        repeat (2) cyc();
        chk("ar_pre_score", 32'(bus.score), 1);
        #2 reset = 1'b1;
        #1;
        chk("ar_phase", 32'(bus.phase), 0);
        chk("ar_score", 32'(bus.score), 0);
        chk("ar_round", 32'(bus.round_idx), 0);
        chk("ar_lc", 32'(bus.last_correct), 0);
        chk("ar_tl", 32'(bus.time_left), 0);
        chk("ar_nq", 32'(bus.new_question), 0);
        bus.start = 1'b1;
        repeat (3) cyc();
        chk("ar_start_ignored", 32'(bus.phase), 0);
        bus.start = 1'b0;
        #3 reset = 1'b0;
        cyc();
        chk("ar_rel_phase", 32'(bus.phase), 0);
        chk("ar_rel_nq", 32'(bus.new_question), 0);
        chk("ar_rel_done", 32'(bus.done), 0);
        pulse_start();
        chk("ar_post_phase", 32'(bus.phase), 1);
        chk("ar_post_nq", 32'(bus.new_question), 1);
        measure(2'b01, n); chk("ar_post_show_len", 32'(n), 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end
endmodule
